// File: rtl/free_list_if.sv
// Rename/ROB-facing signal bundle of the physical-register free list.
// The master side (rename + ROB) drives requests and releases. The slave side
// (the free list) returns the head tag, the occupancy and the error status.
interface free_list_if #(
  parameter int unsigned NUM_PREGS = 64
);
  localparam int unsigned TAG_W = $clog2(NUM_PREGS);
  localparam int unsigned CNT_W = $clog2(NUM_PREGS) + 1;

  logic                 alloc_req;
  logic                 alloc_valid;
  logic [TAG_W-1:0]     alloc_preg;
  logic [NUM_PREGS-1:0] retire_vec;
  logic [CNT_W-1:0]     free_count;
  logic [NUM_PREGS-1:0] free_vec;
  logic                 dbl_free_err;
  logic                 overflow_err;

  modport master (
    output alloc_req, retire_vec,
    input  alloc_valid, alloc_preg, free_count, free_vec, dbl_free_err, overflow_err
  );

  modport slave (
    input  alloc_req, retire_vec,
    output alloc_valid, alloc_preg, free_count, free_vec, dbl_free_err, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags with a shadow bitmap.
// One pop per cycle to rename. Up to two releases per cycle from the ROB retire
// vector. Duplicate releases are rejected against the bitmap. Physical register 0
// is never released.
module free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned ARCH_REGS = 32
) (
  input logic        clk,
  input logic        rstn,
  free_list_if.slave fl
);
  localparam int unsigned TAG_W = $clog2(NUM_PREGS);
  localparam int unsigned CNT_W = $clog2(NUM_PREGS) + 1;

  logic [TAG_W-1:0]     fifo_q [NUM_PREGS];
  logic [TAG_W-1:0]     head_q, head_d;
  logic [TAG_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_PREGS-1:0] free_q, free_d;
  logic                 dbl_q, dbl_d;
  logic                 ovf_q, ovf_d;

  logic [NUM_PREGS-1:0] cand;
  logic                 has_a, has_b, extra;
  logic [TAG_W-1:0]     tag_a, tag_b;
  logic                 acc_a, acc_b, pop;
  logic                 wr0_en, wr1_en;
  logic [TAG_W-1:0]     wr0_tag, wr1_tag;

  // Pick the two lowest set release candidates (bit 0 excluded) and flag any beyond them.
  always_comb begin
    cand    = fl.retire_vec;
    cand[0] = 1'b0;
    has_a   = 1'b0;
    has_b   = 1'b0;
    extra   = 1'b0;
    tag_a   = '0;
    tag_b   = '0;
    for (int unsigned i = 1; i < NUM_PREGS; i++) begin
      if (cand[i]) begin
        if (!has_a) begin
          has_a = 1'b1;
          tag_a = TAG_W'(i);
        end else if (!has_b) begin
          has_b = 1'b1;
          tag_b = TAG_W'(i);
        end else begin
          extra = 1'b1;
        end
      end
    end
  end

  // Next-state for pointers, count, bitmap and sticky errors.
  // The bitmap is sampled before this cycle's pop clears its bit, so releasing the
  // tag currently being allocated counts as a double free. A rejected duplicate
  // still takes one of the two release slots.
  always_comb begin
    acc_a   = has_a && !free_q[tag_a];
    acc_b   = has_b && !free_q[tag_b];
    pop     = fl.alloc_req && (count_q != '0);
    wr0_en  = acc_a || acc_b;
    wr0_tag = acc_a ? tag_a : tag_b;
    wr1_en  = acc_a && acc_b;
    wr1_tag = tag_b;

    head_d  = head_q + TAG_W'(pop);
    tail_d  = tail_q + TAG_W'(acc_a) + TAG_W'(acc_b);
    count_d = count_q + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(pop);

    free_d = free_q;
    if (pop)   free_d[fifo_q[head_q]] = 1'b0;
    if (acc_a) free_d[tag_a]          = 1'b1;
    if (acc_b) free_d[tag_b]          = 1'b1;

    dbl_d = dbl_q | (has_a && free_q[tag_a]) | (has_b && free_q[tag_b]);
    ovf_d = ovf_q | extra;
  end

  // State registers. Reset loads the non-architectural tags into the FIFO in ascending order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        fifo_q[i] <= (i < NUM_PREGS - ARCH_REGS) ? TAG_W'(i + ARCH_REGS) : '0;
        free_q[i] <= (i >= ARCH_REGS);
      end
      head_q  <= '0;
      tail_q  <= TAG_W'(NUM_PREGS - ARCH_REGS);
      count_q <= CNT_W'(NUM_PREGS - ARCH_REGS);
      dbl_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr0_en) fifo_q[tail_q]          <= wr0_tag;
      if (wr1_en) fifo_q[tail_q + 1'b1]   <= wr1_tag;
      free_q  <= free_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dbl_q   <= dbl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fl.alloc_valid  = (count_q != '0);
  assign fl.alloc_preg   = fifo_q[head_q];
  assign fl.free_count   = count_q;
  assign fl.free_vec     = free_q;
  assign fl.dbl_free_err = dbl_q;
  assign fl.overflow_err = ovf_q;
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, drain order, release latency,
// simultaneous pop/push, pointer wrap, double free, x0 and overflow handling.
module tb_free_list;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  free_list_if #(.NUM_PREGS(64)) fl ();

  free_list #(.NUM_PREGS(64), .ARCH_REGS(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fl   (fl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [63:0] ret);
    fl.alloc_req  = req;
    fl.retire_vec = ret;
    #1;
  endtask

  task automatic chk_reset_image(input string tag);
    chk({tag, "_count"}, 64'(fl.free_count), 64'd32);
    chk({tag, "_valid"}, 64'(fl.alloc_valid), 64'd1);
    chk({tag, "_preg"},  64'(fl.alloc_preg), 64'd32);
    chk({tag, "_fvec"},  fl.free_vec, 64'hFFFF_FFFF_0000_0000);
    chk({tag, "_dbl"},   64'(fl.dbl_free_err), 64'd0);
    chk({tag, "_ovf"},   64'(fl.overflow_err), 64'd0);
  endtask

  logic [63:0] one = 64'd1;
  int unsigned seq [$];

  initial begin
    fl.alloc_req  = 1'b0;
    fl.retire_vec = '0;
    #12;
    chk_reset_image("rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Drain all 32 reset tags in order
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, '0);
      chk("drain_tag", 64'(fl.alloc_preg), 64'(32 + i));
      tick();
    end
    drive(1'b0, '0);
    chk("empty_count", 64'(fl.free_count), 64'd0);
    chk("empty_valid", 64'(fl.alloc_valid), 64'd0);
    drive(1'b1, '0);
    tick();
    drive(1'b0, '0);
    chk("stall_count", 64'(fl.free_count), 64'd0);
    chk("stall_fvec", fl.free_vec, 64'd0);

    // Release 5 and 40 while empty; not allocatable until next cycle
    drive(1'b1, (one << 5) | (one << 40));
    chk("nobypass_valid", 64'(fl.alloc_valid), 64'd0);
    tick();
    drive(1'b0, '0);
    chk("rel_count", 64'(fl.free_count), 64'd2);
    chk("rel_preg", 64'(fl.alloc_preg), 64'd5);
    chk("rel_fvec", fl.free_vec, (one << 5) | (one << 40));
    drive(1'b1, '0);
    tick();
    drive(1'b0, '0);
    chk("rel_preg2", 64'(fl.alloc_preg), 64'd40);
    drive(1'b1, '0);
    tick();
    drive(1'b0, '0);
    chk("rel_drained", 64'(fl.free_count), 64'd0);

    // Build count=10 with tags 10..19
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 64'd3 << (10 + 2 * k));
      tick();
    end
    drive(1'b0, '0);
    chk("ten_count", 64'(fl.free_count), 64'd10);
    drive(1'b1, (one << 7) | (one << 9));
    tick();
    drive(1'b0, '0);
    chk("popush_count", 64'(fl.free_count), 64'd11);
    chk("popush_preg", 64'(fl.alloc_preg), 64'd11);
    chk("popush_fvec", fl.free_vec, ((one << 20) - (one << 11)) | (one << 7) | (one << 9));
    seq = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 7, 9};
    foreach (seq[j]) begin
      drive(1'b1, '0);
      chk("popush_order", 64'(fl.alloc_preg), 64'(seq[j]));
      tick();
    end
    drive(1'b0, '0);
    chk("popush_empty", 64'(fl.free_count), 64'd0);

    // Move tail to 63 with 17 releases (20..36), then pop + push 7,9 across the wrap
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 64'd3 << (20 + 2 * k));
      tick();
    end
    drive(1'b0, one << 36);
    tick();
    drive(1'b0, '0);
    chk("wrap_pre_count", 64'(fl.free_count), 64'd17);
    drive(1'b1, (one << 7) | (one << 9));
    tick();
    drive(1'b0, '0);
    chk("wrap_count", 64'(fl.free_count), 64'd18);
    seq = {};
    for (int unsigned t = 21; t <= 36; t++) seq.push_back(t);
    seq.push_back(7);
    seq.push_back(9);
    foreach (seq[j]) begin
      drive(1'b1, '0);
      chk("wrap_order", 64'(fl.alloc_preg), 64'(seq[j]));
      tick();
    end
    drive(1'b0, '0);
    chk("wrap_empty", 64'(fl.free_count), 64'd0);

    // x0 release is ignored silently
    drive(1'b0, one);
    tick();
    drive(1'b0, '0);
    chk("x0_count", 64'(fl.free_count), 64'd0);
    chk("x0_fvec", fl.free_vec, 64'd0);
    chk("x0_dbl", 64'(fl.dbl_free_err), 64'd0);
    chk("x0_ovf", 64'(fl.overflow_err), 64'd0);

    // Double free of 33
    drive(1'b0, one << 33);
    tick();
    drive(1'b0, one << 33);
    tick();
    drive(1'b0, '0);
    chk("dbl_flag", 64'(fl.dbl_free_err), 64'd1);
    chk("dbl_count", 64'(fl.free_count), 64'd1);
    chk("dbl_preg", 64'(fl.alloc_preg), 64'd33);
    chk("dbl_ovf", 64'(fl.overflow_err), 64'd0);
    // Releasing the tag being popped this cycle is rejected
    drive(1'b1, one << 33);
    tick();
    drive(1'b0, '0);
    chk("dblpop_count", 64'(fl.free_count), 64'd0);
    chk("dblpop_fvec", fl.free_vec, 64'd0);
    chk("dblpop_valid", 64'(fl.alloc_valid), 64'd0);

    // Three candidates: 3 and 4 pushed, 6 dropped
    drive(1'b0, (one << 3) | (one << 4) | (one << 6));
    tick();
    drive(1'b0, '0);
    chk("ovf_flag", 64'(fl.overflow_err), 64'd1);
    chk("ovf_count", 64'(fl.free_count), 64'd2);
    chk("ovf_preg", 64'(fl.alloc_preg), 64'd3);
    chk("ovf_fvec", fl.free_vec, (one << 3) | (one << 4));
    drive(1'b1, '0);
    tick();
    drive(1'b0, '0);
    chk("ovf_preg2", 64'(fl.alloc_preg), 64'd4);

    // Asynchronous reset mid-cycle
    drive(1'b1, one << 50);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_image("midrst");
    drive(1'b0, '0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, '0);
    tick();
    drive(1'b0, '0);
    chk("postrst_preg", 64'(fl.alloc_preg), 64'd33);
    chk("postrst_count", 64'(fl.free_count), 64'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the out-of-order core. It sits between the ROB and the rename stage. It consumes the ROB's per-cycle one-hot retire vector (old destination registers released at commit) and hands one free physical register per cycle to rename for new destinations. It is a 64-entry circular FIFO of 6-bit register tags, with a shadow free bitmap that guards against double frees.

## Interface
- NUM_PREGS, 64: number of physical registers. Tags are 6 bits wide.
- ARCH_REGS, 32: physical registers 0..ARCH_REGS-1 hold the initial architectural mapping at reset.
- clk  in  1  core clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- alloc_req  in  1  rename needs one new destination register this cycle.
- alloc_valid  out  1  a free register is available (count != 0).
- alloc_preg  out  6  tag at the FIFO head. Meaningful only when alloc_valid=1.
- retire_vec  in  64  one-hot-per-bit release vector from the ROB. Bit i=1 frees physical register i.
- free_count  out  7  number of registers currently in the list, 0..63.
- free_vec  out  64  bitmap. Bit i=1 means register i is in the list.
- dbl_free_err  out  1  sticky error flag. Cleared only by reset.
- overflow_err  out  1  sticky error flag: more than two releases were requested in one cycle. Cleared only by reset.

## Operation
- Reset (asynchronous, rstn=0):
  - FIFO entries 0..31 hold tags 32..63 in ascending order.
  - head=0, tail=32 (6-bit pointers), free_count=32.
  - free_vec = {32{1'b1}, 32{1'b0}}.
  - Both error flags = 0. alloc_valid=1, alloc_preg=32.
- Allocation:
  - alloc_preg and alloc_valid are combinational from the registered head and count. There is no output register.
  - A pop occurs on a rising edge when alloc_req=1 and alloc_valid=1. The pop clears free_vec[alloc_preg] and sets head=head+1 mod 64.
  - alloc_req=1 with alloc_valid=0 has no effect. Rename stalls.
- Release:
  - Candidate bits are retire_vec[63:1]. Bit 0 (physical x0) is always ignored and is never freed.
  - At most two releases are accepted per cycle: the two lowest-indexed set candidate bits.
  - The lower tag is written at tail and the higher tag at tail+1. tail advances by the number accepted, mod 64.
  - If a third or later candidate bit is set, it is dropped and overflow_err is set.
  - Double free: a candidate whose free_vec bit is already 1 is not pushed and sets dbl_free_err.
    - This includes a candidate equal to the alloc_preg being popped the same cycle, because free_vec is sampled before update.
    - A rejected duplicate still counts toward the two-per-cycle limit.
  - An accepted release sets its free_vec bit.
- Count arithmetic:
  - free_count_next = free_count + pushes - pop, with pushes in 0..2 and pop in 0..1.
  - The count cannot exceed 63, because x0 is never freed and the bitmap rejects duplicates. The FIFO therefore never overruns.
- No bypass: a register released in cycle N is allocatable no earlier than cycle N+1. This holds even when the list is empty in cycle N.

## Timing
- Allocation latency is 0 cycles: the tag is visible combinationally while alloc_req is high and is consumed at that edge.
- Release-to-available latency is 1 cycle: after edge N, free_count, free_vec and (if the list was empty) alloc_preg reflect the push.
- A pop and up to two pushes in the same cycle are all applied at the same edge. The head and tail pointers are independent.
- Pointer wrap: index 63 + 1 = 0. A two-push that straddles the wrap writes entries 63 and 0.
- Reset asserted mid-operation discards all state immediately, without waiting for a clock, and restores the reset image above. Outputs show the reset values while rstn=0.

## Test plan
- Reset: assert rstn=0 mid-cycle -> immediately free_count=32, alloc_valid=1, alloc_preg=32, free_vec[63:32] all 1 and free_vec[31:0]=0, both error flags 0.
- Drain: alloc_req=1 for 32 cycles -> tags 32,33,...,63 in order. Then alloc_valid=0 and free_count=0. A further alloc_req does not change any state.
- Release while empty: from empty, retire_vec bits 5 and 40 set in one cycle -> alloc_valid stays 0 that cycle. On the next cycle free_count=2 and alloc_preg=5. After one pop, alloc_preg=40.
- Simultaneous pop and two pushes: with free_count=10, alloc_req=1 and retire bits 7 and 9 -> free_count=11 and tail advances by 2. Repeat across the wrap point; entries 63 and 0 hold 7 and 9 in that order.
- Double free and x0: retire bit 33 while 33 is still free -> no push and dbl_free_err=1. Retire bit 0 -> ignored, no error raised, free_count unchanged.
- Overflow: retire bits 3, 4 and 6 set, all allocated -> 3 and 4 are pushed, 6 is dropped, overflow_err=1, and free_vec[6] stays 0.
